hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. Generates the EX-stage operand forwarding selects (`forwardCtrl_e`) that drive the two register-data forwarding muxes. Sequences pipeline stalls and flushes for load-use hazards, taken branches and multi-cycle MUL/DIV (MDU) operations. Sits beside the ID/EX/MEM/WB pipeline registers and drives their stall and flush enables.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding, load-use/branch/MDU stall and flush sequencing.
// Zero-latency comb selects/stalls; state, busy counter and sticky mdu_err update on clk.
// Optional perf counters under HAZARD_PERF_EN (ports tied to 0 when undefined).

package hazard_pkg;
   typedef enum logic [1:0] {
      FORWARD_NONE     = 2'b00,
      FORWARD_FROM_WB  = 2'b01,
      FORWARD_FROM_MEM = 2'b10
   } forwardCtrl_e;
endpackage

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [4:0]   rs1_id,
   input  logic [4:0]   rs2_id,
   input  logic [4:0]   rs1_ex,
   input  logic [4:0]   rs2_ex,
   input  logic [4:0]   rd_ex,
   input  logic [4:0]   rd_mem,
   input  logic [4:0]   rd_wb,
   input  logic         reg_write_mem,
   input  logic         reg_write_wb,
   input  logic         mem_read_ex,
   input  logic         mdu_start_ex,
   input  logic         mdu_done,
   input  logic         branch_taken_ex,
   output forwardCtrl_e forward_a_sel,
   output forwardCtrl_e forward_b_sel,
   output logic         stall_if,
   output logic         stall_id,
   output logic         stall_ex,
   output logic         flush_id,
   output logic         flush_ex,
   output logic         flush_mem,
   output logic         mdu_err,
   output logic [31:0]  stall_cycles,
   output logic [31:0]  flush_count
);

   localparam int CNT_W = ($clog2(MDU_TIMEOUT) > 16) ? $clog2(MDU_TIMEOUT) : 16;

   typedef enum logic {RUN, MDU_BUSY} state_e;

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic               load_use;
   logic               timeout;

   function automatic forwardCtrl_e fwd_sel(input logic [4:0] src);
      fwd_sel = FORWARD_NONE;
      if (reg_write_mem && rd_mem != 5'd0 && rd_mem == src)
         fwd_sel = FORWARD_FROM_MEM;
      else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == src)
         fwd_sel = FORWARD_FROM_WB;
   endfunction

   assign load_use = mem_read_ex && (rd_ex != 5'd0) && (rd_ex == rs1_id || rd_ex == rs2_id);
   assign timeout  = (cnt == CNT_W'(MDU_TIMEOUT - 1));

   always_comb begin
      forward_a_sel = FORWARD_NONE;
      forward_b_sel = FORWARD_NONE;
      if (rst_n) begin
         forward_a_sel = fwd_sel(rs1_ex);
         forward_b_sel = fwd_sel(rs2_ex);
      end
   end

   // Reset forces every enable low, independent of the pipeline inputs.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      flush_mem = 1'b0;
      if (rst_n) begin
         case (state)
            RUN: begin
               if (mdu_start_ex && !mdu_done) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  flush_mem = 1'b1;
               end else if (branch_taken_ex) begin
                  flush_id = 1'b1;
                  flush_ex = 1'b1;
               end else if (load_use) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ex = 1'b1;
               end
            end
            MDU_BUSY: begin
               if (!mdu_done && !timeout) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  flush_mem = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         cnt     <= '0;
         mdu_err <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mdu_start_ex && !mdu_done) begin
                  state <= MDU_BUSY;
                  cnt   <= '0;
               end
            end
            MDU_BUSY: begin
               // mdu_done takes precedence over a coincident timeout.
               if (mdu_done) begin
                  state <= RUN;
               end else if (timeout) begin
                  state   <= RUN;
                  mdu_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_if)
            stall_cycles <= stall_cycles + 32'd1;
         if (flush_id || flush_ex)
            flush_count <= flush_count + 32'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected enables pushed at drive time, compared at negedge.
// Built with MDU_TIMEOUT=8 so the timeout path is reachable in a few cycles.

module tb_hazard_ctrl;
   import hazard_pkg::*;

   typedef struct packed {
      logic [4:0] rs1_id;
      logic [4:0] rs2_id;
      logic [4:0] rs1_ex;
      logic [4:0] rs2_ex;
      logic [4:0] rd_ex;
      logic [4:0] rd_mem;
      logic [4:0] rd_wb;
      logic       reg_write_mem;
      logic       reg_write_wb;
      logic       mem_read_ex;
      logic       mdu_start_ex;
      logic       mdu_done;
      logic       branch_taken_ex;
   } in_t;

   typedef struct packed {
      forwardCtrl_e fa;
      forwardCtrl_e fb;
      logic [5:0]   sf;
      logic         err;
   } exp_t;

   // {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem}
   localparam logic [5:0] SF_NONE = 6'b000_000;
   localparam logic [5:0] SF_MDU  = 6'b111_001;
   localparam logic [5:0] SF_BR   = 6'b000_110;
   localparam logic [5:0] SF_LU   = 6'b110_010;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [4:0]   rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic         reg_write_mem, reg_write_wb, mem_read_ex;
   logic         mdu_start_ex, mdu_done, branch_taken_ex;
   forwardCtrl_e forward_a_sel, forward_b_sel;
   logic         stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem;
   logic         mdu_err;
   logic [31:0]  stall_cycles, flush_count;

   int           n_cmp = 0;
   int           n_err = 0;
   exp_t         exp_q[$];
   string        tag_q[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.MDU_TIMEOUT(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs1_id          (rs1_id),
      .rs2_id          (rs2_id),
      .rs1_ex          (rs1_ex),
      .rs2_ex          (rs2_ex),
      .rd_ex           (rd_ex),
      .rd_mem          (rd_mem),
      .rd_wb           (rd_wb),
      .reg_write_mem   (reg_write_mem),
      .reg_write_wb    (reg_write_wb),
      .mem_read_ex     (mem_read_ex),
      .mdu_start_ex    (mdu_start_ex),
      .mdu_done        (mdu_done),
      .branch_taken_ex (branch_taken_ex),
      .forward_a_sel   (forward_a_sel),
      .forward_b_sel   (forward_b_sel),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .stall_ex        (stall_ex),
      .flush_id        (flush_id),
      .flush_ex        (flush_ex),
      .flush_mem       (flush_mem),
      .mdu_err         (mdu_err),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input in_t s,
                       input forwardCtrl_e fa, input forwardCtrl_e fb,
                       input logic [5:0] sf, input logic err);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n           = rst;
      rs1_id          = s.rs1_id;
      rs2_id          = s.rs2_id;
      rs1_ex          = s.rs1_ex;
      rs2_ex          = s.rs2_ex;
      rd_ex           = s.rd_ex;
      rd_mem          = s.rd_mem;
      rd_wb           = s.rd_wb;
      reg_write_mem   = s.reg_write_mem;
      reg_write_wb    = s.reg_write_wb;
      mem_read_ex     = s.mem_read_ex;
      mdu_start_ex    = s.mdu_start_ex;
      mdu_done        = s.mdu_done;
      branch_taken_ex = s.branch_taken_ex;
      e.fa  = fa;
      e.fb  = fb;
      e.sf  = sf;
      e.err = err;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   exp_t  mon_e;
   string mon_t;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         mon_t = tag_q.pop_front();
         check_val({mon_t, ".fa"}, 32'(forward_a_sel), 32'(mon_e.fa));
         check_val({mon_t, ".fb"}, 32'(forward_b_sel), 32'(mon_e.fb));
         check_val({mon_t, ".sf"},
                   32'({stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem}),
                   32'(mon_e.sf));
         check_val({mon_t, ".err"}, 32'(mdu_err), 32'(mon_e.err));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t z, s;
      logic [31:0] exp_sc, exp_fc;
      z = '0;
      rst_n = 1'b0;
      {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
      {reg_write_mem, reg_write_wb, mem_read_ex, mdu_start_ex, mdu_done, branch_taken_ex} = '0;

      // Reset dominates live hazard inputs.
      s = z; s.rs1_ex = 5; s.rd_mem = 5; s.reg_write_mem = 1; s.mdu_start_ex = 1;
      s.branch_taken_ex = 1;
      step("reset", 1'b0, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      step("idle", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);

      // Forwarding priority and gating.
      s = z; s.rs1_ex = 5; s.rd_mem = 5; s.reg_write_mem = 1; s.rd_wb = 5; s.reg_write_wb = 1;
      step("fwd_mem_wins", 1'b1, s, FORWARD_FROM_MEM, FORWARD_NONE, SF_NONE, 1'b0);
      s.rd_mem = 0;
      step("fwd_wb_rdmem0", 1'b1, s, FORWARD_FROM_WB, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.rs1_ex = 7; s.rs2_ex = 7; s.rd_mem = 7; s.reg_write_mem = 0;
      s.rd_wb = 7; s.reg_write_wb = 1;
      step("fwd_wen_gate", 1'b1, s, FORWARD_FROM_WB, FORWARD_FROM_WB, SF_NONE, 1'b0);
      s = z; s.rs1_ex = 9; s.rd_mem = 9; s.reg_write_mem = 1; s.rs2_ex = 0;
      s.rd_wb = 0; s.reg_write_wb = 1;
      step("fwd_x0", 1'b1, s, FORWARD_FROM_MEM, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.rs2_ex = 12; s.rd_mem = 11; s.reg_write_mem = 1; s.rd_wb = 12; s.reg_write_wb = 1;
      step("fwd_b_wb", 1'b1, s, FORWARD_NONE, FORWARD_FROM_WB, SF_NONE, 1'b0);

      // Load-use: one stall cycle, bubble clears it.
      s = z; s.mem_read_ex = 1; s.rd_ex = 3; s.rs2_id = 3;
      step("lu_hit", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_LU, 1'b0);
      s = z; s.rs2_id = 3;
      step("lu_bubble", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.mem_read_ex = 1; s.rd_ex = 0; s.rs1_id = 0;
      step("lu_x0", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.mem_read_ex = 1; s.rd_ex = 3; s.rs1_id = 3; s.branch_taken_ex = 1;
      step("br_over_lu", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_BR, 1'b0);

      // Same-cycle MDU start+done falls through to lower rules.
      s = z; s.mdu_start_ex = 1; s.mdu_done = 1;
      step("mdu_fast", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s.mem_read_ex = 1; s.rd_ex = 4; s.rs1_id = 4;
      step("mdu_fast_lu", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_LU, 1'b0);
      step("after_fast", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);

      // MDU with done at T+5, then one branch; counters start from reset.
      step("reset2", 1'b0, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.mdu_start_ex = 1;
      step("mdu_t0", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_MDU, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         s = z; s.mdu_start_ex = 1;
         s.branch_taken_ex = (k == 2);
         s.mem_read_ex = (k == 3); s.rd_ex = 6; s.rs1_id = 6;
         step($sformatf("mdu_t%0d", k), 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_MDU, 1'b0);
      end
      s = z; s.mdu_start_ex = 1; s.mdu_done = 1;
      step("mdu_t5_done", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.branch_taken_ex = 1;
      step("mdu_t6_run_br", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_BR, 1'b0);
      step("mdu_t7", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      exp_sc = 32'd5;
      exp_fc = 32'd1;
`else
      exp_sc = 32'd0;
      exp_fc = 32'd0;
`endif
      check_val("perf_stall_cycles", stall_cycles, exp_sc);
      check_val("perf_flush_count", flush_count, exp_fc);

      // done coinciding with timeout: release without error.
      s = z; s.mdu_start_ex = 1;
      for (int k = 0; k <= 7; k++)
         step($sformatf("tie_t%0d", k), 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_MDU, 1'b0);
      s.mdu_done = 1;
      step("tie_done", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      step("tie_after", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);

      // Timeout: 8 stalled cycles, then forced release and sticky error.
      s = z; s.mdu_start_ex = 1;
      for (int k = 0; k <= 7; k++)
         step($sformatf("to_t%0d", k), 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_MDU, 1'b0);
      step("to_release", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      step("to_err", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b1);
      s = z; s.branch_taken_ex = 1;
      step("to_sticky_br", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_BR, 1'b1);
      step("to_sticky", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b1);
      step("to_reset", 1'b0, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      step("post_reset", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      s = z; s.mdu_start_ex = 1;
      step("post_run_mdu", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_MDU, 1'b0);
      s.mdu_done = 1;
      step("post_done", 1'b1, s, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);
      step("end_idle", 1'b1, z, FORWARD_NONE, FORWARD_NONE, SF_NONE, 1'b0);

      repeat (3) @(negedge clk);
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
